// File: rtl/design_mux_pkg.sv
// Shared types and constants for the sequenced design-select multiplexer.
package design_mux_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        RST_NEW
    } mux_state_t;

    // Wide enough for a switch reset of up to 255 cycles and for the debounce count.
    localparam int CNT_W = 8;

    function automatic logic sel_valid(input int sel, input int num_des);
        return sel < num_des;
    endfunction

endpackage

// File: rtl/io_sync.sv
// Plain flop chain with synchronous clear, used to retime the pad inputs.
module io_sync #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/design_mux_sequenced.sv
// Routes chip IO pins to one of NUM_DES design slots, with debounced selection
// and a drain / reset sequence whenever the routed slot changes.
//   state   | meaning
//   ACTIVE  | selected slot is live, io_out follows it, des_sel is debounced
//   DRAIN   | one cycle with outputs zeroed before the handover
//   RST_NEW | new slot held in reset for SWITCH_RST_CYCLES cycles
module design_mux_sequenced
    import design_mux_pkg::*;
#(
    parameter int NUM_DES           = 64,
    parameter int IO_W              = 12,
    parameter int SEL_W             = $clog2(NUM_DES),
    parameter int SYNC_STAGES       = 2,
    parameter int SEL_STABLE        = 2,
    parameter int SWITCH_RST_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IO_W-1:0]         io_in,
    output logic [IO_W-1:0]         io_out,
    input  logic [SEL_W-1:0]        des_sel,
    input  logic                    hold_if_not_sel,
    input  logic                    sync_inputs,
    output logic [NUM_DES*IO_W-1:0] des_io_in,
    input  logic [NUM_DES*IO_W-1:0] des_io_out,
    output logic [NUM_DES-1:0]      des_reset,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    switching
);

    mux_state_t       state_q, state_d;
    logic [SEL_W-1:0] active_d;
    logic [SEL_W-1:0] pending_q, pending_d;
    logic [SEL_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [IO_W-1:0]  io_out_d;
    logic [IO_W-1:0]  sync_q;
    logic [IO_W-1:0]  pin_in;
    logic             sel_ok;

    io_sync #(
        .WIDTH  (IO_W),
        .STAGES (SYNC_STAGES)
    ) u_io_sync (
        .clock (clock),
        .reset (reset),
        .d     (io_in),
        .q     (sync_q)
    );

    assign pin_in    = sync_inputs ? sync_q : io_in;
    assign sel_ok    = sel_valid(int'(des_sel), NUM_DES);
    assign switching = (state_q != ACTIVE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RST_NEW;
            rcnt_q     <= CNT_W'(SWITCH_RST_CYCLES);
            active_sel <= sel_ok ? des_sel : '0;
            pending_q  <= '0;
            cand_q     <= '0;
            dcnt_q     <= '0;
            io_out     <= '0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            active_sel <= active_d;
            pending_q  <= pending_d;
            cand_q     <= cand_d;
            dcnt_q     <= dcnt_d;
            io_out     <= io_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        active_d  = active_sel;
        pending_d = pending_q;
        cand_d    = cand_q;
        dcnt_d    = '0;
        io_out_d  = '0;
        case (state_q)
            ACTIVE: begin
                io_out_d = des_io_out[int'(active_sel)*IO_W +: IO_W];
                if (!sel_ok || des_sel == active_sel) begin
                    dcnt_d = '0;
                end else if (des_sel == cand_q) begin
                    dcnt_d = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
                end else begin
                    cand_d = des_sel;
                    dcnt_d = CNT_W'(1);
                end
                // Switch fires on the edge where the count reaches the threshold.
                if (int'(dcnt_d) >= SEL_STABLE) begin
                    pending_d = cand_d;
                    dcnt_d    = '0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                active_d = pending_q;
                rcnt_d   = CNT_W'(SWITCH_RST_CYCLES);
                state_d  = RST_NEW;
            end
            RST_NEW: begin
                if (rcnt_q <= CNT_W'(1)) state_d = ACTIVE;
                else                     rcnt_d  = rcnt_q - 1'b1;
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_comb begin
        des_io_in = '0;
        des_reset = '0;
        for (int i = 0; i < NUM_DES; i++) begin
            if (i == int'(active_sel)) begin
                des_reset[i] = reset | (state_q == RST_NEW);
                if (state_q == ACTIVE) des_io_in[i*IO_W +: IO_W] = pin_in;
            end else if (hold_if_not_sel) begin
                des_reset[i] = 1'b1;
            end else begin
                des_reset[i]               = reset;
                des_io_in[i*IO_W +: IO_W] = pin_in;
            end
        end
    end

endmodule

// File: tb/tb_design_mux_sequenced.sv
// Directed bench for design_mux_sequenced: cycle-level behavioural model plus
// pinned literal expectations along the scripted scenario.
module tb_design_mux_sequenced;

    localparam int NUM_DES     = 64;
    localparam int IO_W        = 12;
    localparam int SEL_W       = 7;   // one spare bit so out-of-range requests can be driven
    localparam int SYNC_STAGES = 2;
    localparam int SEL_STABLE  = 2;
    localparam int RST_CYC     = 4;
    localparam int BUS_W       = NUM_DES*IO_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [IO_W-1:0]   io_in = '0;
    logic [IO_W-1:0]   io_out;
    logic [SEL_W-1:0]  des_sel = 7'd3;
    logic              hold_if_not_sel = 1'b1;
    logic              sync_inputs = 1'b1;
    logic [BUS_W-1:0]  des_io_in;
    logic [BUS_W-1:0]  des_io_out = '0;
    logic [NUM_DES-1:0] des_reset;
    logic [SEL_W-1:0]  active_sel;
    logic              switching;

    int vectors = 0;
    int miscompares = 0;

    design_mux_sequenced #(
        .NUM_DES           (NUM_DES),
        .IO_W              (IO_W),
        .SEL_W             (SEL_W),
        .SYNC_STAGES       (SYNC_STAGES),
        .SEL_STABLE        (SEL_STABLE),
        .SWITCH_RST_CYCLES (RST_CYC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_in           (io_in),
        .io_out          (io_out),
        .des_sel         (des_sel),
        .hold_if_not_sel (hold_if_not_sel),
        .sync_inputs     (sync_inputs),
        .des_io_in       (des_io_in),
        .des_io_out      (des_io_out),
        .des_reset       (des_reset),
        .active_sel      (active_sel),
        .switching       (switching)
    );

    always #5 clock = ~clock;

    function automatic logic [IO_W-1:0] slot_pattern(input int i);
        if (i == 3) return 12'hA5A;
        return IO_W'(i*37 + 5);
    endfunction

    task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "live" means the chosen slot is connected; otherwise it is either
    // in its one drain cycle or counting down its remaining reset cycles.
    bit              m_valid = 0;
    bit              m_live, m_drain;
    int              m_wait, m_sel, m_target, m_run_val, m_run_len, m_req;
    logic [IO_W-1:0] m_io_out, m_next_out;
    logic [IO_W-1:0] m_pipe [SYNC_STAGES];

    always @(posedge clock) begin
        m_req = int'(des_sel);
        if (reset) begin
            m_valid   = 1;
            m_sel     = (m_req < NUM_DES) ? m_req : 0;
            m_live    = 0;
            m_drain   = 0;
            m_wait    = RST_CYC;
            m_run_val = 0;
            m_run_len = 0;
            m_io_out  = '0;
            for (int k = 0; k < SYNC_STAGES; k++) m_pipe[k] = '0;
        end else if (m_valid) begin
            m_next_out = m_live ? des_io_out[m_sel*IO_W +: IO_W] : '0;
            if (m_live) begin
                if (m_req >= NUM_DES || m_req == m_sel) m_run_len = 0;
                else if (m_req == m_run_val) m_run_len = m_run_len + 1;
                else begin
                    m_run_val = m_req;
                    m_run_len = 1;
                end
                if (m_run_len >= SEL_STABLE) begin
                    m_live    = 0;
                    m_drain   = 1;
                    m_target  = m_run_val;
                    m_run_len = 0;
                end
            end else if (m_drain) begin
                m_drain = 0;
                m_sel   = m_target;
                m_wait  = RST_CYC;
            end else begin
                m_wait = m_wait - 1;
                if (m_wait == 0) m_live = 1;
            end
            m_io_out = m_next_out;
            for (int k = SYNC_STAGES-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = io_in;
        end
    end

    logic [IO_W-1:0]    e_pin;
    logic [BUS_W-1:0]   e_in;
    logic [NUM_DES-1:0] e_rst;

    always @(negedge clock) begin
        if (m_valid) begin
            e_pin = sync_inputs ? m_pipe[SYNC_STAGES-1] : io_in;
            e_in  = '0;
            e_rst = '0;
            for (int i = 0; i < NUM_DES; i++) begin
                if (i == m_sel) begin
                    e_rst[i] = reset | (!m_live && !m_drain);
                    if (m_live) e_in[i*IO_W +: IO_W] = e_pin;
                end else begin
                    e_rst[i] = hold_if_not_sel ? 1'b1 : reset;
                    if (!hold_if_not_sel) e_in[i*IO_W +: IO_W] = e_pin;
                end
            end
            check("io_out", BUS_W'(io_out), BUS_W'(m_io_out));
            check("active_sel", BUS_W'(active_sel), BUS_W'(m_sel));
            check("switching", BUS_W'(switching), BUS_W'(!m_live));
            check("des_reset", BUS_W'(des_reset), BUS_W'(e_rst));
            check("des_io_in", des_io_in, e_in);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        for (int i = 0; i < NUM_DES; i++) des_io_out[i*IO_W +: IO_W] = slot_pattern(i);

        // Reset onto slot 3, then a 4-cycle reset pulse before it goes live.
        cyc(); cyc();
        reset = 1'b0;
        for (int k = 0; k < RST_CYC; k++) begin
            #1;
            check("lit_rst_pulse3", BUS_W'(des_reset[3]), 1);
            check("lit_io_out_zero", BUS_W'(io_out), 0);
            check("lit_active3", BUS_W'(active_sel), 3);
            cyc();
        end
        #1 check("lit_live_after_rst", BUS_W'(switching), 0);
        check("lit_io_out_lag", BUS_W'(io_out), 0);
        cyc();
        #1 check("lit_io_out_a5a", BUS_W'(io_out), 12'hA5A);

        // Single-cycle glitch is not a switch.
        des_sel = 7'd9; cyc();
        des_sel = 7'd3; cyc(); cyc();
        #1 check("lit_glitch_sw", BUS_W'(switching), 0);
        check("lit_glitch_sel", BUS_W'(active_sel), 3);

        // Out-of-range request is ignored.
        des_sel = 7'd70;
        repeat (5) cyc();
        #1 check("lit_oor_sw", BUS_W'(switching), 0);
        check("lit_oor_sel", BUS_W'(active_sel), 3);

        // Held request for slot 7: debounce, drain, reset, live.
        des_sel = 7'd7; cyc();
        #1 check("lit_debounce1", BUS_W'(switching), 0);
        cyc();
        #1 check("lit_drain_sw", BUS_W'(switching), 1);
        check("lit_drain_sel", BUS_W'(active_sel), 3);
        cyc();
        for (int k = 0; k < RST_CYC; k++) begin
            #1;
            check("lit_active7", BUS_W'(active_sel), 7);
            check("lit_rst_pulse7", BUS_W'(des_reset[7]), 1);
            check("lit_sw_io_zero", BUS_W'(io_out), 0);
            check("lit_sw_busy", BUS_W'(switching), 1);
            cyc();
        end
        #1 check("lit_live7", BUS_W'(switching), 0);
        cyc();
        #1 check("lit_io_out7", BUS_W'(io_out), slot_pattern(7));

        // Unselected slots held, then broadcast through the synchroniser.
        io_in = 12'hFFF; hold_if_not_sel = 1'b1; cyc();
        #1 check("lit_hold_in5", BUS_W'(des_io_in[5*IO_W +: IO_W]), 0);
        check("lit_hold_rst5", BUS_W'(des_reset[5]), 1);
        hold_if_not_sel = 1'b0;
        cyc(); cyc(); cyc();
        #1 check("lit_bcast_in5", BUS_W'(des_io_in[5*IO_W +: IO_W]), 12'hFFF);
        check("lit_bcast_rst5", BUS_W'(des_reset[5]), 0);
        check("lit_bcast_in7", BUS_W'(des_io_in[7*IO_W +: IO_W]), 12'hFFF);
        sync_inputs = 1'b0; io_in = 12'h123;
        #1 check("lit_unsync_in5", BUS_W'(des_io_in[5*IO_W +: IO_W]), 12'h123);
        cyc();

        // Reset during a switch restarts on the current des_sel.
        sync_inputs = 1'b1; io_in = 12'h3C3; des_sel = 7'd3;
        cyc(); cyc(); cyc();
        des_sel = 7'd5; cyc();
        #1 check("lit_mid_not_latched", BUS_W'(active_sel), 3);
        check("lit_mid_busy", BUS_W'(switching), 1);
        reset = 1'b1; cyc();
        reset = 1'b0;
        for (int k = 0; k < RST_CYC; k++) begin
            #1;
            check("lit_active5", BUS_W'(active_sel), 5);
            check("lit_rst_pulse5", BUS_W'(des_reset[5]), 1);
            cyc();
        end
        #1 check("lit_live5", BUS_W'(switching), 0);

        // Return to ACTIVE with a differing request starts a fresh debounce.
        des_sel = 7'd2; hold_if_not_sel = 1'b1;
        repeat (8) cyc();
        #1 check("lit_active2", BUS_W'(active_sel), 2);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
